pb_event_unit: RTL and testbench
================================

# pb_event_unit

Debounces the board push buttons and turns them into clean, single-cycle control events for the counter/display control stage that consumes them. Provides a debounced level, press and release pulses, and a hold/auto-repeat mechanism, all timed from an internally generated 1 kHz tick. Sits directly between the raw `PUSH_BUTTON_N_I` pins and the control logic that toggles stop/direction/display mode.

## Interface
- `NUM_BUTTONS`, 4: number of button channels.
- `TICK_PERIOD`, 50000: `CLOCK_50_I` cycles per 1 kHz tick; range 2..65535.
- `DEBOUNCE_LEN`, 10: width of the per-button sample shift register, in ticks.
- `HOLD_TICKS`, 500: number of ticks a button must stay held before it counts as a long press.
- `REPEAT_TICKS`, 100: number of ticks between auto-repeat pulses once a long press is active.

Ports:
- `CLOCK_50_I` in 1: 50 MHz clock; the only clock.
- `resetn` in 1: asynchronous, active-low reset.
- `PUSH_BUTTON_N_I` in NUM_BUTTONS: raw buttons, active low, asynchronous to the clock.
- `tick_1kHz_o` out 1: one-cycle strobe, once every TICK_PERIOD cycles.
- `pb_status_o` out NUM_BUTTONS: debounced level, 1 = pressed.
- `pb_press_o` out NUM_BUTTONS: one-cycle pulse on a debounced press.
- `pb_release_o` out NUM_BUTTONS: one-cycle pulse on a debounced release.
- `pb_long_o` out NUM_BUTTONS: level, high while a long press is active.
- `pb_repeat_o` out NUM_BUTTONS: one-cycle pulse at long-press entry, then every REPEAT_TICKS ticks while held.

## Operation
- **Tick counter.** 16-bit counter counts 0..TICK_PERIOD-1, then wraps. `tick_1kHz_o` is high in the cycle where the count equals TICK_PERIOD-1.
- **Synchroniser.** Each raw input passes through a 2-flop synchroniser and is inverted, so 1 = pressed.
- **Sampling.** On each tick, the synchronised sample is shifted into bit 0 of that button's DEBOUNCE_LEN shift register.
- **Debounced level.** `pb_status_o[i]` is a register loaded every cycle with the OR of shift register i.
  - Press is recognised on the first pressed sample.
  - Release is recognised only after DEBOUNCE_LEN consecutive released samples.
- **Edge pulses.** Registered from the status and its one-cycle-delayed copy:
  - press = rising edge of status;
  - release = falling edge of status.
- **Per-button FSM.**
  - IDLE → PRESSED on a rising edge of status. The 10-bit hold counter is cleared.
  - PRESSED: the hold counter increments on each tick. When it reaches HOLD_TICKS-1 on a tick: go to HELD, assert `pb_repeat_o` once, clear the counter.
  - HELD: `pb_long_o` = 1. The counter increments on each tick. When it reaches REPEAT_TICKS-1 on a tick: pulse `pb_repeat_o` and clear the counter.
  - Any state → IDLE when status is 0. This clears the counter and `pb_long_o`.
- **Simultaneous events.**
  - If release and the hold threshold occur in the same cycle, release wins: no repeat pulse, no HELD.
  - Channels are fully independent; several buttons may pulse in the same cycle.
- **Counter saturation.** The hold counter saturates at 1023 and never wraps.
- **Reset values.** Reset, including mid-operation, clears all state and outputs to 0. FSMs return to IDLE. The next press after reset produces a fresh press pulse.
  - Shift registers reset to 0, so a button held through reset registers as a press on the first tick after reset.

## Timing
- Tick T is the cycle where `tick_1kHz_o` = 1. The shift register updates at the end of T.
- `pb_status_o` changes at the end of T+1.
- `pb_press_o` / `pb_release_o` are high during cycle T+2 only.
- `pb_long_o` rises and the first `pb_repeat_o` pulse occurs 2 cycles after the tick that completes HOLD_TICKS ticks in PRESSED.
- Raw input to sample latency is 2 cycles (synchroniser), plus the wait for the next tick.
- Press latency is at most one tick period plus 4 cycles.
- Release latency is DEBOUNCE_LEN ticks, ±1 tick.
- All outputs are registered; there are no combinational input-to-output paths.

## Structure
- **Package `pb_event_pkg`:**
  - `pb_state_t` enum {PB_IDLE, PB_PRESSED, PB_HELD};
  - `HOLD_CNT_W` = 10;
  - `TICK_CNT_W` = 16.
- **Top-level logic:** the tick counter and the synchronisers.
- **Sub-module `pb_channel`:** one button's shift register, status, edge pulses, FSM and hold counter. Instantiated NUM_BUTTONS times with a generate loop.

## Test plan
All scenarios use TICK_PERIOD=10, DEBOUNCE_LEN=4, HOLD_TICKS=5, REPEAT_TICKS=3.
- **Reset.** Assert `resetn`=0 mid-run → all outputs 0 immediately. After release, the first tick occurs 10 cycles later.
- **Clean press.** Hold PB0 low for 20 ticks → exactly one `pb_press_o[0]` pulse, 2 cycles after the first tick that samples it low. `pb_status_o[0]`=1 throughout.
- **Bounce.** Toggle PB1 every 3 cycles for 30 cycles, then hold it low → one press pulse only, and no release pulse.
- **Release.** Release PB2 after 3 ticks → `pb_release_o[2]` pulses 4 ticks (±1) later. `pb_long_o[2]` never asserts.
- **Long press.** Hold PB3 for 15 ticks → `pb_long_o[3]` rises after 5 ticks, with `pb_repeat_o[3]` pulses at ticks 5, 8, 11, 14. Release → `pb_long_o[3]` clears in the same cycle as the release pulse.
- **Simultaneous.** Press PB0 and PB3 in the same cycle → both press pulses in the same cycle. Release exactly at the 5th tick → no repeat pulse.

Source files
------------

// File: rtl/pb_event_pkg.sv
// Shared types and widths for the push-button event unit.
package pb_event_pkg;

    localparam int HOLD_CNT_W = 10;
    localparam int TICK_CNT_W = 16;

    typedef enum logic [1:0] {
        PB_IDLE    = 2'd0,
        PB_PRESSED = 2'd1,
        PB_HELD    = 2'd2
    } pb_state_t;

    // Hold counter never wraps; it parks at all-ones.
    function automatic logic [HOLD_CNT_W-1:0] hold_cnt_inc(input logic [HOLD_CNT_W-1:0] cnt);
        return (&cnt) ? cnt : cnt + 1'b1;
    endfunction

endpackage

// File: rtl/pb_channel.sv
// One button: tick-sampled debounce shift register, level/edge outputs,
// and the idle/pressed/held FSM that produces long-press and auto-repeat.
module pb_channel
    import pb_event_pkg::*;
#(
    parameter int DEBOUNCE_LEN = 10,
    parameter int HOLD_TICKS   = 500,
    parameter int REPEAT_TICKS = 100
) (
    input  logic      i_clk,
    input  logic      i_rst_n,
    input  logic      i_tick,
    input  logic      i_sample,
    output logic      o_status,
    output logic      o_press,
    output logic      o_release,
    output logic      o_long,
    output logic      o_repeat,
    output pb_state_t o_state
);

    localparam logic [HOLD_CNT_W-1:0] HOLD_LAST   = HOLD_CNT_W'(HOLD_TICKS - 1);
    localparam logic [HOLD_CNT_W-1:0] REPEAT_LAST = HOLD_CNT_W'(REPEAT_TICKS - 1);

    logic [DEBOUNCE_LEN-1:0] r_shift;
    logic                    r_status;
    logic                    r_tick_d;
    logic                    r_press;
    logic                    r_release;
    logic                    r_long;
    logic                    r_repeat;
    pb_state_t               r_state;
    logic [HOLD_CNT_W-1:0]   r_hold_cnt;

    logic                    w_level;
    logic                    w_rise;
    pb_state_t               w_state_nxt;
    logic [HOLD_CNT_W-1:0]   w_cnt_nxt;
    logic                    w_long_nxt;
    logic                    w_repeat_nxt;

    // w_level is the value status takes next cycle; the FSM and edge pulses
    // decide on it so that they line up with the status register.
    assign w_level = |r_shift;
    assign w_rise  = w_level & ~r_status;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_shift   <= '0;
            r_status  <= 1'b0;
            r_tick_d  <= 1'b0;
            r_press   <= 1'b0;
            r_release <= 1'b0;
        end else begin
            if (i_tick) begin
                r_shift <= {r_shift[DEBOUNCE_LEN-2:0], i_sample};
            end
            r_status  <= w_level;
            r_tick_d  <= i_tick;
            r_press   <= w_rise;
            r_release <= ~w_level & r_status;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state    <= PB_IDLE;
            r_hold_cnt <= '0;
            r_long     <= 1'b0;
            r_repeat   <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_hold_cnt <= w_cnt_nxt;
            r_long     <= w_long_nxt;
            r_repeat   <= w_repeat_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_hold_cnt;
        if (!w_level) begin
            w_state_nxt = PB_IDLE;
            w_cnt_nxt   = '0;
        end else begin
            case (r_state)
                PB_IDLE: begin
                    if (w_rise) begin
                        w_state_nxt = PB_PRESSED;
                        w_cnt_nxt   = '0;
                    end
                end
                PB_PRESSED: begin
                    if (r_tick_d) begin
                        if (r_hold_cnt == HOLD_LAST) begin
                            w_state_nxt = PB_HELD;
                            w_cnt_nxt   = '0;
                        end else begin
                            w_cnt_nxt = hold_cnt_inc(r_hold_cnt);
                        end
                    end
                end
                PB_HELD: begin
                    if (r_tick_d) begin
                        if (r_hold_cnt == REPEAT_LAST) begin
                            w_cnt_nxt = '0;
                        end else begin
                            w_cnt_nxt = hold_cnt_inc(r_hold_cnt);
                        end
                    end
                end
                default: begin
                    w_state_nxt = PB_IDLE;
                    w_cnt_nxt   = '0;
                end
            endcase
        end
    end

    // A release landing on the threshold tick suppresses the repeat pulse.
    always_comb begin
        w_long_nxt   = (w_state_nxt == PB_HELD);
        w_repeat_nxt = w_level && r_tick_d &&
                       (((r_state == PB_PRESSED) && (r_hold_cnt == HOLD_LAST)) ||
                        ((r_state == PB_HELD) && (r_hold_cnt == REPEAT_LAST)));
    end

    assign o_status  = r_status;
    assign o_press   = r_press;
    assign o_release = r_release;
    assign o_long    = r_long;
    assign o_repeat  = r_repeat;
    assign o_state   = r_state;

endmodule

// File: rtl/pb_event_unit.sv
// Push-button front end: 1 kHz tick generator, input synchronisers and one
// debounce/event channel per button.
module pb_event_unit
    import pb_event_pkg::*;
#(
    parameter int NUM_BUTTONS  = 4,
    parameter int TICK_PERIOD  = 50000,
    parameter int DEBOUNCE_LEN = 10,
    parameter int HOLD_TICKS   = 500,
    parameter int REPEAT_TICKS = 100
) (
    input  logic                     CLOCK_50_I,
    input  logic                     resetn,
    input  logic [NUM_BUTTONS-1:0]   PUSH_BUTTON_N_I,
    output logic                     tick_1kHz_o,
    output logic [NUM_BUTTONS-1:0]   pb_status_o,
    output logic [NUM_BUTTONS-1:0]   pb_press_o,
    output logic [NUM_BUTTONS-1:0]   pb_release_o,
    output logic [NUM_BUTTONS-1:0]   pb_long_o,
    output logic [NUM_BUTTONS-1:0]   pb_repeat_o,
    output logic [2*NUM_BUTTONS-1:0] pb_state_dbg_o
);

    localparam logic [TICK_CNT_W-1:0] TICK_LAST = TICK_CNT_W'(TICK_PERIOD - 1);
    localparam logic [TICK_CNT_W-1:0] TICK_PRE  = TICK_CNT_W'(TICK_PERIOD - 2);

    logic [TICK_CNT_W-1:0]  r_tick_cnt;
    logic                   r_tick;
    logic [NUM_BUTTONS-1:0] r_sync1;
    logic [NUM_BUTTONS-1:0] r_sync2;
    pb_state_t              w_state [NUM_BUTTONS];

    // r_tick is registered one count early so it is high while the count is at its last value.
    always_ff @(posedge CLOCK_50_I or negedge resetn) begin
        if (!resetn) begin
            r_tick_cnt <= '0;
            r_tick     <= 1'b0;
        end else begin
            r_tick_cnt <= (r_tick_cnt == TICK_LAST) ? '0 : r_tick_cnt + 1'b1;
            r_tick     <= (r_tick_cnt == TICK_PRE);
        end
    end

    always_ff @(posedge CLOCK_50_I or negedge resetn) begin
        if (!resetn) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= ~PUSH_BUTTON_N_I;
            r_sync2 <= r_sync1;
        end
    end

    assign tick_1kHz_o = r_tick;

    for (genvar g = 0; g < NUM_BUTTONS; g++) begin : g_chan
        pb_channel #(
            .DEBOUNCE_LEN (DEBOUNCE_LEN),
            .HOLD_TICKS   (HOLD_TICKS),
            .REPEAT_TICKS (REPEAT_TICKS)
        ) u_chan (
            .i_clk     (CLOCK_50_I),
            .i_rst_n   (resetn),
            .i_tick    (r_tick),
            .i_sample  (r_sync2[g]),
            .o_status  (pb_status_o[g]),
            .o_press   (pb_press_o[g]),
            .o_release (pb_release_o[g]),
            .o_long    (pb_long_o[g]),
            .o_repeat  (pb_repeat_o[g]),
            .o_state   (w_state[g])
        );
        assign pb_state_dbg_o[2*g +: 2] = w_state[g];
    end

endmodule

// File: tb/tb_pb_event_unit.sv
// Directed bench for pb_event_unit with TICK_PERIOD=10, DEBOUNCE_LEN=4,
// HOLD_TICKS=5, REPEAT_TICKS=3; pulse events go through an expected-event queue.
module tb_pb_event_unit;

    localparam int EW = 28;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic [3:0]  pb_n = 4'hF;
    logic        tick;
    logic [3:0]  status, press, rel, long_o, rep;
    logic [7:0]  dbg;

    int          cyc;
    int          checks = 0;
    int          failures = 0;
    logic [EW-1:0] exp_q[$];
    logic [EW-1:0] mon_got;
    logic [EW-1:0] mon_exp;
    logic          long_seen;

    pb_event_unit #(
        .NUM_BUTTONS  (4),
        .TICK_PERIOD  (10),
        .DEBOUNCE_LEN (4),
        .HOLD_TICKS   (5),
        .REPEAT_TICKS (3)
    ) dut (
        .CLOCK_50_I      (clk),
        .resetn          (resetn),
        .PUSH_BUTTON_N_I (pb_n),
        .tick_1kHz_o     (tick),
        .pb_status_o     (status),
        .pb_press_o      (press),
        .pb_release_o    (rel),
        .pb_long_o       (long_o),
        .pb_repeat_o     (rep),
        .pb_state_dbg_o  (dbg)
    );

    // ---------------- clock / reset-relative cycle count ----------------
    always #5 clk = ~clk;

    always @(posedge clk or negedge resetn) begin
        if (!resetn) cyc <= 0;
        else         cyc <= cyc + 1;
    end

    // ---------------- helpers ----------------
    function automatic logic [EW-1:0] ev(input int c, input logic [3:0] p,
                                         input logic [3:0] r, input logic [3:0] rp);
        logic [15:0] c16;
        c16 = c[15:0];
        return {c16, p, r, rp};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic wait_cycle(input int c);
        int guard;
        guard = 0;
        @(negedge clk);
        while (cyc < c && guard < 2000) begin
            @(negedge clk);
            guard++;
        end
        if (cyc != c) check("wait_cycle", 32'(cyc), 32'(c));
    endtask

    task automatic do_reset();
        @(negedge clk);
        resetn = 1'b0;
        #1;
        check("reset_outputs", 32'({tick, status, press, rel, long_o, rep, dbg}), 32'd0);
        repeat (3) @(negedge clk);
        resetn = 1'b1;
    endtask

    // ---------------- scoreboard monitor ----------------
    always @(negedge clk) begin
        if (resetn && (|press || |rel || |rep)) begin
            mon_got = {cyc[15:0], press, rel, rep};
            if (exp_q.size() == 0) begin
                check("unexpected_event", 32'(mon_got), 32'd0);
            end else begin
                mon_exp = exp_q.pop_front();
                check("event", 32'(mon_got), 32'(mon_exp));
            end
        end
    end

    // ---------------- directed scenarios ----------------
    initial begin
        // Reset and tick spacing
        do_reset();
        wait_cycle(8);  check("tick_c8", 32'(tick), 32'd0);
        wait_cycle(9);  check("tick_c9", 32'(tick), 32'd1);
        wait_cycle(10); check("tick_c10", 32'(tick), 32'd0);
        wait_cycle(19); check("tick_c19", 32'(tick), 32'd1);

        // Clean long hold on PB0; release completes on a repeat tick
        do_reset();
        exp_q.push_back(ev(11, 4'b0001, 4'b0000, 4'b0000));
        for (int k = 0; k < 6; k++) exp_q.push_back(ev(61 + 30 * k, 4'b0000, 4'b0000, 4'b0001));
        exp_q.push_back(ev(241, 4'b0000, 4'b0001, 4'b0000));
        wait_cycle(5);   pb_n[0] = 1'b0;
        wait_cycle(10);  check("b_status_c10", 32'(status), 32'h0);
        wait_cycle(11);  check("b_status_c11", 32'(status), 32'h1);
        wait_cycle(60);  check("b_long_c60", 32'(long_o), 32'h0);
        wait_cycle(61);  check("b_long_c61", 32'(long_o), 32'h1);
        wait_cycle(205); pb_n[0] = 1'b1;
        wait_cycle(240); check("b_status_c240", 32'(status), 32'h1);
                         check("b_long_c240", 32'(long_o), 32'h1);
        wait_cycle(241); check("b_status_c241", 32'(status), 32'h0);
                         check("b_long_c241", 32'(long_o), 32'h0);
        wait_cycle(260); check("b_drained", 32'(exp_q.size()), 32'd0);

        // Bounce on PB1, then reset while held and press again after reset
        do_reset();
        exp_q.push_back(ev(11, 4'b0010, 4'b0000, 4'b0000));
        for (int c = 7; c < 37; c++) begin
            wait_cycle(c);
            pb_n[1] = (((c - 7) / 3) % 2) != 0;
        end
        wait_cycle(37);  pb_n[1] = 1'b0;
        wait_cycle(50);  check("c_status_c50", 32'(status), 32'h2);
                         check("c_drained", 32'(exp_q.size()), 32'd0);
        do_reset();
        exp_q.push_back(ev(11, 4'b0010, 4'b0000, 4'b0000));
        wait_cycle(10);  check("c_status_after_rst_c10", 32'(status), 32'h0);
        wait_cycle(11);  check("c_status_after_rst_c11", 32'(status), 32'h2);
        wait_cycle(20);  check("c_drained2", 32'(exp_q.size()), 32'd0);
        pb_n[1] = 1'b1;

        // Short press on PB2: release pulse, never long
        do_reset();
        exp_q.push_back(ev(11, 4'b0100, 4'b0000, 4'b0000));
        exp_q.push_back(ev(51, 4'b0000, 4'b0100, 4'b0000));
        long_seen = 1'b0;
        for (int c = 5; c <= 70; c++) begin
            wait_cycle(c);
            if (c == 5)  pb_n[2] = 1'b0;
            if (c == 15) pb_n[2] = 1'b1;
            long_seen = long_seen | long_o[2];
            if (c == 50) check("d_status_c50", 32'(status), 32'h4);
            if (c == 51) check("d_status_c51", 32'(status), 32'h0);
        end
        check("d_long_never", 32'(long_seen), 32'd0);
        check("d_drained", 32'(exp_q.size()), 32'd0);

        // Long press on PB3 with repeats at ticks 5, 8, 11, 14
        do_reset();
        exp_q.push_back(ev(11, 4'b1000, 4'b0000, 4'b0000));
        for (int k = 0; k < 4; k++) exp_q.push_back(ev(61 + 30 * k, 4'b0000, 4'b0000, 4'b1000));
        exp_q.push_back(ev(181, 4'b0000, 4'b1000, 4'b0000));
        wait_cycle(5);   pb_n[3] = 1'b0;
        wait_cycle(30);  check("e_state_c30", 32'(dbg[7:6]), 32'd1);
        wait_cycle(60);  check("e_long_c60", 32'(long_o), 32'h0);
        wait_cycle(61);  check("e_long_c61", 32'(long_o), 32'h8);
                         check("e_state_c61", 32'(dbg[7:6]), 32'd2);
        wait_cycle(145); pb_n[3] = 1'b1;
        wait_cycle(180); check("e_long_c180", 32'(long_o), 32'h8);
        wait_cycle(181); check("e_long_c181", 32'(long_o), 32'h0);
                         check("e_state_c181", 32'(dbg[7:6]), 32'd0);
        wait_cycle(200); check("e_drained", 32'(exp_q.size()), 32'd0);

        // PB0 and PB3 together; release completes on the hold-threshold tick
        do_reset();
        exp_q.push_back(ev(11, 4'b1001, 4'b0000, 4'b0000));
        exp_q.push_back(ev(61, 4'b0000, 4'b1001, 4'b0000));
        wait_cycle(5);   pb_n = 4'b0110;
        wait_cycle(25);  pb_n = 4'b1111;
        wait_cycle(60);  check("f_status_c60", 32'(status), 32'h9);
                         check("f_state_c60", 32'(dbg), 32'h41);
        wait_cycle(61);  check("f_long_c61", 32'(long_o), 32'h0);
                         check("f_status_c61", 32'(status), 32'h0);
        wait_cycle(62);  check("f_long_c62", 32'(long_o), 32'h0);
        wait_cycle(80);  check("f_drained", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        failures++;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
